ecmac_col_drain: RTL

Column-bottom drain for the error-compensation systolic MAC array. It receives the partial sum and the deferred error product leaving the last MAC row of one column. It folds in the outstanding compensation term, `result = partial_sum + error_product`, and buffers the corrected results in a small FIFO. The FIFO is read by the output writer through a valid/ready handshake, with results grouped into tiles of fixed length.

---
 rtl/ecmac_pkg.sv | 14 +
 rtl/ecmac_res_fifo.sv | 64 ++++++
 rtl/ecmac_col_drain.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ecmac_pkg.sv
// Shared constants and result-entry layout for the error-compensation MAC array
// and its column drain.
package ecmac_pkg;

    localparam int ECMAC_PS_W = 24;
    localparam int ECMAC_EP_W = 16;

    typedef struct packed {
        logic [ECMAC_PS_W-1:0] data;
        logic                  sat;
        logic                  last;
    } ecmac_res_t;

endpackage

// File: rtl/ecmac_res_fifo.sv
// First-word-fall-through FIFO for corrected column results; a push is taken
// while full only when a pop happens in the same cycle.
module ecmac_res_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         head_valid,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          empty_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign empty_s    = (count_r == '0);
    assign full       = (count_r == FULL_CNT);
    assign pop_ok_s   = pop && !empty_s;
    assign push_ok_s  = push && (!full || pop_ok_s);
    assign head_valid = !empty_s;
    // Head is forced to zero when empty so every output reads 0 in reset.
    assign head_data  = empty_s ? '0 : mem_r[rd_ptr_r];

    // Storage array write port
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ecmac_col_drain.sv
// Column-bottom drain: adds the deferred error product to the partial sum and
// queues results in tiles. Optional saturation is enabled by ECMAC_SAT_EN.
module ecmac_col_drain
    import ecmac_pkg::*;
#(
    parameter int PS_W     = ECMAC_PS_W,
    parameter int EP_W     = ECMAC_EP_W,
    parameter int DEPTH    = 8,
    parameter int TILE_LEN = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [PS_W-1:0] partial_sum_in,
    input  logic [EP_W-1:0] error_product_in,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [PS_W-1:0] res_data,
    output logic            res_last,
    output logic            res_sat,
    output logic            drop_err,
    output logic [15:0]     comp_count
);

    localparam int TC_W = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
    localparam logic [TC_W-1:0] TILE_END = TC_W'(TILE_LEN - 1);
`ifdef ECMAC_SAT_EN
    localparam int EW = PS_W + 2;
`else
    localparam int EW = PS_W + 1;
`endif

    logic [PS_W-1:0] data_s;
    logic            sat_s;
    logic            last_s;
    logic [PS_W-1:0] s1_data_r;
    logic            s1_sat_r;
    logic            s1_last_r;
    logic            s1_valid_r;
    logic [TC_W-1:0] tile_cnt_r;
    logic [15:0]     comp_count_r;
    logic            drop_err_r;
    logic [EW-1:0]   push_data_s;
    logic [EW-1:0]   head_s;
    logic            head_valid_s;
    logic            full_s;
    logic            pop_s;

`ifdef ECMAC_SAT_EN
    logic [PS_W:0] sum_s;
`else
    logic [PS_W-1:0] sum_s;
`endif

    // Compensation adder with optional saturation on carry-out
    always_comb begin
        last_s = (tile_cnt_r == TILE_END);
`ifdef ECMAC_SAT_EN
        sum_s = {1'b0, partial_sum_in} + (PS_W+1)'(error_product_in);
        if (sum_s[PS_W]) begin
            data_s = {PS_W{1'b1}};
            sat_s  = 1'b1;
        end else begin
            data_s = sum_s[PS_W-1:0];
            sat_s  = 1'b0;
        end
`else
        sum_s  = partial_sum_in + PS_W'(error_product_in);
        data_s = sum_s;
        sat_s  = 1'b0;
`endif
    end

    // Stage register, tile counter and compensation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_data_r    <= '0;
            s1_sat_r     <= 1'b0;
            s1_last_r    <= 1'b0;
            tile_cnt_r   <= '0;
            comp_count_r <= 16'd0;
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_data_r  <= data_s;
                s1_sat_r   <= sat_s;
                s1_last_r  <= last_s;
                tile_cnt_r <= last_s ? '0 : tile_cnt_r + TC_W'(1);
                if (error_product_in != '0) begin
                    comp_count_r <= comp_count_r + 16'd1;
                end
            end
        end
    end

    assign pop_s = head_valid_s && res_ready;

    // Sticky loss flag: a push meets a full FIFO with no pop to make room
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_err_r <= 1'b0;
        end else if (s1_valid_r && full_s && !pop_s) begin
            drop_err_r <= 1'b1;
        end else begin
            drop_err_r <= drop_err_r;
        end
    end

`ifdef ECMAC_SAT_EN
    assign push_data_s = {s1_data_r, s1_sat_r, s1_last_r};
    assign res_sat     = head_s[1];
`else
    assign push_data_s = {s1_data_r, s1_last_r};
    assign res_sat     = 1'b0;
`endif

    ecmac_res_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (s1_valid_r),
        .push_data  (push_data_s),
        .pop        (pop_s),
        .head_data  (head_s),
        .head_valid (head_valid_s),
        .full       (full_s)
    );

    assign res_valid  = head_valid_s;
    assign res_data   = head_s[EW-1 -: PS_W];
    assign res_last   = head_s[0];
    assign drop_err   = drop_err_r;
    assign comp_count = comp_count_r;

endmodule
